// File: rtl/bpu_pkg.sv
// ----------------------------------------------------------------------------
// bpu_pkg
// Shared types and constants for the branch predictor / mispredict unit.
// The localparams describe the default configuration (32-bit PC, 16-entry
// BTB, 2-bit counters, 16-bit statistics); btb_entry_t is the layout of one
// BTB entry in that configuration.
// ----------------------------------------------------------------------------
package bpu_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int ENTRIES_DEF = 16;
    localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
    localparam int TAG_W_DEF   = PC_W_DEF - IDX_W_DEF - 2;
    localparam int CNT_W_DEF   = 2;
    localparam int STAT_W_DEF  = 16;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [PC_W_DEF-1:0]  target;
        logic [CNT_W_DEF-1:0] ctr;
    } btb_entry_t;

    // Weakly taken: MSB set, rest clear. Weakly not-taken: MSB clear, rest set.
    localparam logic [CNT_W_DEF-1:0] CTR_WEAK_T  = CNT_W_DEF'(1) << (CNT_W_DEF - 1);
    localparam logic [CNT_W_DEF-1:0] CTR_WEAK_NT = CTR_WEAK_T - CNT_W_DEF'(1);

    // opcode[6:4] of BRANCH / JAL / JALR.
    localparam logic [2:0] OPC_CTRL = 3'b110;

endpackage

// File: rtl/bpu_sat_ctr.sv
// ----------------------------------------------------------------------------
// bpu_sat_ctr
// Next-value logic for a W-bit saturating counter. Counts up on i_inc, down
// on i_dec, holds at all-ones and at zero. With UP_ONLY set the decrement
// path is removed (used for the statistics counters).
// Ports:
//   i_val  - current counter value
//   i_inc  - request increment
//   i_dec  - request decrement (ignored when UP_ONLY)
//   o_next - value the counter should take at the next edge
// ----------------------------------------------------------------------------
module bpu_sat_ctr #(
    parameter int W       = 2,
    parameter bit UP_ONLY = 1'b0
) (
    input  logic [W-1:0] i_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_next
);

    logic w_dec;
    logic w_at_max;
    logic w_at_min;

    assign w_dec    = i_dec & ~UP_ONLY;
    assign w_at_max = &i_val;
    assign w_at_min = ~|i_val;

    always_comb begin
        // NOTE: o_next gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_next = i_val;
        if (i_inc && !w_dec) begin
            if (!w_at_max) o_next = i_val + W'(1);
        end else if (w_dec && !i_inc) begin
            if (!w_at_min) o_next = i_val - W'(1);
        end
    end

endmodule

// File: rtl/bpu_btb_predictor.sv
// ----------------------------------------------------------------------------
// bpu_btb_predictor
// Direct-mapped BTB with per-entry saturating counters for the IF stage, plus
// mispredict detection, flush generation and table training from EX.
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   if_pc_i            - PC being fetched
//   pred_hit_o         - BTB valid + tag match for if_pc_i
//   pred_taken_o       - hit and counter MSB set
//   pred_pc_o          - predicted next PC (target or if_pc_i+4)
//   ex_valid_i         - EX holds a real instruction
//   ex_ctrl_i          - EX instruction is branch/JAL/JALR
//   ex_pc_i            - PC of the EX instruction
//   ex_taken_i         - resolved direction
//   ex_target_i        - resolved target
//   id_pc_i            - PC currently in ID (path the front end followed)
//   mispredict_o       - resolved next PC differs from id_pc_i
//   redirect_pc_o      - resolved next PC
//   flush_if_id_o      - flush IF/ID
//   flush_id_ex_o      - flush ID/EX
//   branch_cnt_o       - resolved control instructions (saturating)
//   mispred_cnt_o      - mispredicts (saturating)
// ----------------------------------------------------------------------------
module bpu_btb_predictor
    import bpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PC_W-1:0]   if_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [PC_W-1:0]   pred_pc_o,
    input  logic              ex_valid_i,
    input  logic              ex_ctrl_i,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic              ex_taken_i,
    input  logic [PC_W-1:0]   ex_target_i,
    input  logic [PC_W-1:0]   id_pc_i,
    output logic              mispredict_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CTR_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CTR_NT = CTR_T - CNT_W'(1);

    // Same layout as bpu_pkg::btb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } entry_t;

    entry_t              r_table [ENTRIES];
    logic [STAT_W-1:0]   r_branch_cnt;
    logic [STAT_W-1:0]   r_mispred_cnt;

    // ---------------- IF-side lookup ----------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    entry_t           w_if_entry;

    assign w_if_idx   = if_pc_i[IDX_W+1:2];
    assign w_if_tag   = if_pc_i[PC_W-1:IDX_W+2];
    assign w_if_entry = r_table[w_if_idx];

    assign pred_hit_o   = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign pred_taken_o = pred_hit_o && w_if_entry.ctr[CNT_W-1];
    assign pred_pc_o    = pred_taken_o ? w_if_entry.target : if_pc_i + PC_W'(4);

    // ---------------- EX-side resolve ----------------
    logic             w_resolve;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    entry_t           w_ex_entry;
    logic             w_ex_hit;
    logic [CNT_W-1:0] w_ctr_next;

    // rst_ni gates resolve so a control instruction seen during reset neither
    // flushes nor trains.
    assign w_resolve = rst_ni && ex_valid_i && ex_ctrl_i;

    assign redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + PC_W'(4);
    assign mispredict_o  = w_resolve && (redirect_pc_o != id_pc_i);
    assign flush_if_id_o = mispredict_o;
    assign flush_id_ex_o = mispredict_o;

    assign w_ex_idx   = ex_pc_i[IDX_W+1:2];
    assign w_ex_tag   = ex_pc_i[PC_W-1:IDX_W+2];
    assign w_ex_entry = r_table[w_ex_idx];
    assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

    bpu_sat_ctr #(.W(CNT_W), .UP_ONLY(1'b0)) u_dir_ctr (
        .i_val  (w_ex_entry.ctr),
        .i_inc  (ex_taken_i),
        .i_dec  (~ex_taken_i),
        .o_next (w_ctr_next)
    );

    // ---------------- Table update ----------------
    // Lookups read r_table directly, so a write becomes visible one cycle
    // later; an IF lookup of the index being trained sees the old entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: every entry is reset because the valid bits must clear
            // and counters start weakly not-taken; a pure data RAM would not
            // need this.
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_NT};
            end
        end else if (w_resolve) begin
            if (w_ex_hit) begin
                // NOTE: non-blocking assignments keep every register update in
                // this block reading pre-edge values.
                r_table[w_ex_idx].ctr <= w_ctr_next;
                if (ex_taken_i) r_table[w_ex_idx].target <= ex_target_i;
            end else if (ex_taken_i) begin
                // Miss and taken: overwrite whatever aliases at this index.
                r_table[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag,
                                       target: ex_target_i, ctr: CTR_T};
            end
        end
    end

    // ---------------- Statistics ----------------
    logic [STAT_W-1:0] w_branch_next;
    logic [STAT_W-1:0] w_mispred_next;

    bpu_sat_ctr #(.W(STAT_W), .UP_ONLY(1'b1)) u_branch_stat (
        .i_val  (r_branch_cnt),
        .i_inc  (w_resolve),
        .i_dec  (1'b0),
        .o_next (w_branch_next)
    );

    bpu_sat_ctr #(.W(STAT_W), .UP_ONLY(1'b1)) u_mispred_stat (
        .i_val  (r_mispred_cnt),
        .i_inc  (mispredict_o),
        .i_dec  (1'b0),
        .o_next (w_mispred_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_branch_cnt  <= w_branch_next;
            r_mispred_cnt <= w_mispred_next;
        end
    end

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_bpu_btb_predictor.sv
// ----------------------------------------------------------------------------
// tb_bpu_btb_predictor
// Directed bench for bpu_btb_predictor (ENTRIES=16, CNT_W=2, STAT_W=4).
// Expected values are queued when stimulus is driven and popped when the
// corresponding DUT output is sampled.
// ----------------------------------------------------------------------------
module tb_bpu_btb_predictor;
    import bpu_pkg::*;

    localparam int PC_W    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk_i;
    logic              rst_ni;
    logic [PC_W-1:0]   if_pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [PC_W-1:0]   pred_pc_o;
    logic              ex_valid_i;
    logic              ex_ctrl_i;
    logic [PC_W-1:0]   ex_pc_i;
    logic              ex_taken_i;
    logic [PC_W-1:0]   ex_target_i;
    logic [PC_W-1:0]   id_pc_i;
    logic              mispredict_o;
    logic [PC_W-1:0]   redirect_pc_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic [STAT_W-1:0] branch_cnt_o;
    logic [STAT_W-1:0] mispred_cnt_o;

    bpu_btb_predictor #(
        .PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .if_pc_i       (if_pc_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_pc_o     (pred_pc_o),
        .ex_valid_i    (ex_valid_i),
        .ex_ctrl_i     (ex_ctrl_i),
        .ex_pc_i       (ex_pc_i),
        .ex_taken_i    (ex_taken_i),
        .ex_target_i   (ex_target_i),
        .id_pc_i       (id_pc_i),
        .mispredict_o  (mispredict_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef enum {S_HIT, S_TAKEN, S_PRED, S_MISP, S_FL_IFID, S_FL_IDEX,
                  S_REDIR, S_BR, S_MP} sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t   sb_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    string step    = "";
    int    exp_br  = 0;
    int    exp_mp  = 0;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;

    function automatic logic [31:0] sample(sig_e s);
        case (s)
            S_HIT:     return {31'b0, pred_hit_o};
            S_TAKEN:   return {31'b0, pred_taken_o};
            S_PRED:    return pred_pc_o;
            S_MISP:    return {31'b0, mispredict_o};
            S_FL_IFID: return {31'b0, flush_if_id_o};
            S_FL_IDEX: return {31'b0, flush_id_ex_o};
            S_REDIR:   return redirect_pc_o;
            S_BR:      return {{(32-STAT_W){1'b0}}, branch_cnt_o};
            S_MP:      return {{(32-STAT_W){1'b0}}, mispred_cnt_o};
            default:   return 'x;
        endcase
    endfunction

    task automatic push(input sig_e s, input logic [31:0] v);
        sb_t e;
        e.sig = s;
        e.exp = v;
        e.tag = $sformatf("%s/%s", step, s.name());
        sb_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pop every queued expectation and compare against the DUT right now.
    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, sample(e.sig), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic probe(input logic [31:0] pc, input logic hit, input logic taken,
                         input logic [31:0] pred);
        if_pc_i = pc;
        push(S_HIT, {31'b0, hit});
        push(S_TAKEN, {31'b0, taken});
        push(S_PRED, pred);
        #1;
        drain();
    endtask

    // Present one EX instruction for a cycle, check the combinational resolve
    // outputs, clock it in, then check the statistics counters.
    task automatic ex_step(input logic valid, input logic [6:0] opcode,
                           input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic [31:0] id_pc);
        logic        ctrl;
        logic [31:0] redir;
        logic        misp;
        ctrl        = (opcode[6:4] == OPC_CTRL);
        ex_valid_i  = valid;
        ex_ctrl_i   = ctrl;
        ex_pc_i     = pc;
        ex_taken_i  = taken;
        ex_target_i = target;
        id_pc_i     = id_pc;
        redir = taken ? target : pc + 32'd4;
        misp  = valid && ctrl && (redir != id_pc);
        push(S_MISP, {31'b0, misp});
        push(S_FL_IFID, {31'b0, misp});
        push(S_FL_IDEX, {31'b0, misp});
        if (misp) push(S_REDIR, redir);
        #1;
        drain();
        tick();
        ex_valid_i = 1'b0;
        if (valid && ctrl && exp_br < STAT_MAX) exp_br++;
        if (misp && exp_mp < STAT_MAX) exp_mp++;
        push(S_BR, exp_br);
        push(S_MP, exp_mp);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        if_pc_i     = '0;
        ex_valid_i  = 1'b0;
        ex_ctrl_i   = 1'b0;
        ex_pc_i     = '0;
        ex_taken_i  = 1'b0;
        ex_target_i = '0;
        id_pc_i     = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: empty table after reset
        step = "reset";
        push(S_BR, 0);
        push(S_MP, 0);
        drain();
        probe(32'h40, 1'b0, 1'b0, 32'h44);

        // 2: first taken resolve allocates; IF sees the old entry this cycle
        step = "alloc";
        if_pc_i = 32'h40;
        push(S_HIT, 0);
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h44);
        probe(32'h40, 1'b1, 1'b1, 32'h100);

        // 3: counter training on 0x40 (starts weakly taken, 10)
        step = "nt1";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b0, 32'h100, 32'h44);
        probe(32'h40, 1'b1, 1'b0, 32'h44);
        step = "nt2";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b0, 32'h100, 32'h44);
        probe(32'h40, 1'b1, 1'b0, 32'h44);
        step = "nt3_sat0";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b0, 32'h100, 32'h44);
        probe(32'h40, 1'b1, 1'b0, 32'h44);
        step = "t1_from0";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h100);
        probe(32'h40, 1'b1, 1'b0, 32'h44);
        step = "t2";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h100);
        probe(32'h40, 1'b1, 1'b1, 32'h100);
        step = "t3_t4";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h100);
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h100);
        probe(32'h40, 1'b1, 1'b1, 32'h100);
        step = "nt_from_sat3";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b0, 32'h100, 32'h44);
        probe(32'h40, 1'b1, 1'b1, 32'h100);

        // 4: aliasing victim and not-taken miss
        step = "alias";
        ex_step(1'b1, OPC_BRANCH, 32'h80, 1'b1, 32'h200, 32'h84);
        probe(32'h80, 1'b1, 1'b1, 32'h200);
        probe(32'h40, 1'b0, 1'b0, 32'h44);
        step = "nt_miss";
        ex_step(1'b1, OPC_BRANCH, 32'hC0, 1'b0, 32'h300, 32'hC4);
        probe(32'h80, 1'b1, 1'b1, 32'h200);
        probe(32'hC0, 1'b0, 1'b0, 32'hC4);

        // 5: correct prediction, non-control EX, bubble EX
        step = "correct";
        ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h100);
        probe(32'h40, 1'b1, 1'b1, 32'h100);
        step = "non_ctrl";
        ex_step(1'b1, OPC_ALU, 32'h40, 1'b1, 32'h300, 32'h999);
        probe(32'h40, 1'b1, 1'b1, 32'h100);
        step = "bubble";
        ex_step(1'b0, OPC_BRANCH, 32'h40, 1'b1, 32'h300, 32'h500);
        probe(32'h40, 1'b1, 1'b1, 32'h100);

        // 6: statistics saturation
        for (int i = 0; i < 20; i++) begin
            step = $sformatf("misp_run%0d", i);
            ex_step(1'b1, OPC_BRANCH, 32'h40, 1'b1, 32'h100, 32'h0);
        end
        step = "stat_sat";
        push(S_MP, STAT_MAX);
        push(S_BR, STAT_MAX);
        drain();

        // Reset while a resolve is present: no flush, no training, stats clear
        step = "rst_resolve";
        rst_ni      = 1'b0;
        ex_valid_i  = 1'b1;
        ex_ctrl_i   = 1'b1;
        ex_pc_i     = 32'h40;
        ex_taken_i  = 1'b1;
        ex_target_i = 32'h100;
        id_pc_i     = 32'h0;
        push(S_MISP, 0);
        push(S_FL_IFID, 0);
        push(S_FL_IDEX, 0);
        #1;
        drain();
        tick();
        rst_ni     = 1'b1;
        ex_valid_i = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        step = "post_rst";
        push(S_BR, 0);
        push(S_MP, 0);
        drain();
        probe(32'h40, 1'b0, 1'b0, 32'h44);
        probe(32'h80, 1'b0, 1'b0, 32'h84);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bpu_btb_predictor.md
Name: bpu_btb_predictor

Overview:
- Parametrised branch predictor and mispredict-resolution unit for the 5-stage RV32I pipeline.
- IF side: a direct-mapped branch target buffer with per-entry saturating counters supplies a predicted next PC.
- EX side: the resolved next PC is compared against the PC actually in ID. On mismatch the unit raises flush/redirect and trains the table.
- Adds registered mispredict/branch statistics counters.

Parameters:
- PC_W, 32, PC and target width.
- ENTRIES, 16, BTB entries; power of two, >=2. IDX_W = log2(ENTRIES). TAG_W = PC_W-IDX_W-2.
- CNT_W, 2, saturating counter width, >=1. Predict taken when MSB=1.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- if_pc_i  in  PC_W  PC being fetched.
- pred_hit_o  out  1  BTB valid+tag match for if_pc_i.
- pred_taken_o  out  1  hit && counter MSB.
- pred_pc_o  out  PC_W  predicted next PC: pred_taken ? stored target : if_pc_i+4.
- ex_valid_i  in  1  EX holds a real instruction (not a bubble).
- ex_ctrl_i  in  1  EX instruction is branch/JAL/JALR (opcode[6:4]==3'b110).
- ex_pc_i  in  PC_W  PC of the EX instruction.
- ex_taken_i  in  1  resolved direction; always 1 for jumps.
- ex_target_i  in  PC_W  resolved target (ALU result).
- id_pc_i  in  PC_W  PC currently in ID, i.e. the path the front end followed.
- mispredict_o  out  1  resolved next PC != id_pc_i.
- redirect_pc_o  out  PC_W  resolved next PC (ex_taken_i ? ex_target_i : ex_pc_i+4).
- flush_if_id_o  out  1  flush IF/ID register.
- flush_id_ex_o  out  1  flush ID/EX register.
- branch_cnt_o  out  STAT_W  resolved control instructions, saturating.
- mispred_cnt_o  out  STAT_W  mispredicts, saturating.

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Each entry holds valid, tag, target and CNT_W-bit counter.
- Lookup is combinational from registered table state. A write is visible from the next cycle only; there is no write-to-read bypass. If IF and EX hit the same index in the same cycle, IF reads the old entry.
- resolve = rst_ni && ex_valid_i && ex_ctrl_i.
- mispredict_o = resolve && (redirect_pc_o != id_pc_i). It is combinational, same cycle as EX.
- flush_if_id_o = flush_id_ex_o = mispredict_o.
- redirect_pc_o is always driven. Its value is meaningful only when mispredict_o=1.
- Non-control or invalid EX: mispredict_o and both flushes are 0, regardless of id_pc_i.
- Training happens at the clock edge when resolve=1:
  - Hit at ex_pc_i, taken: counter saturating increment, target <= ex_target_i.
  - Hit at ex_pc_i, not taken: counter saturating decrement, target unchanged.
  - Miss, taken: allocate by overwriting the indexed entry (aliasing victim). Set valid=1, tag, target, counter = weakly taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Counter saturates at all-ones and at zero; it never wraps.
- Statistics, at the clock edge:
  - branch_cnt_o increments when resolve=1.
  - mispred_cnt_o increments when mispredict_o=1.
  - Both saturate at 2^STAT_W-1.
- Reset (rst_ni=0 at the edge):
  - All valid bits cleared; counters set to weakly not-taken (MSB=0, rest 1; 0 when CNT_W=1); targets and tags cleared.
  - Statistics counters cleared.
  - A resolve presented in the reset cycle performs no training.
  - mispredict_o and flushes are forced 0 while rst_ni=0.
  - pred_* outputs show a miss from the first cycle after reset.

Decomposition:
- Package bpu_pkg holds:
  - the btb_entry_t struct (valid, tag, target, ctr), parametrised through package-level localparams matching the defaults;
  - the constants CTR_WEAK_T and CTR_WEAK_NT;
  - the opcode-class constant OPC_CTRL = 3'b110.
- One sub-module, bpu_sat_ctr: parametrised CNT_W saturating up/down next-value logic. Also reused for the STAT_W statistics counters in up-only mode.

Test Plan (ENTRIES=16, CNT_W=2, STAT_W=4):
1. Reset, then if_pc_i=0x40 -> pred_hit_o=0, pred_taken_o=0, pred_pc_o=0x44.
2. Resolve ex_pc=0x40, taken, target=0x100, id_pc=0x44 -> same cycle mispredict_o=1, redirect_pc_o=0x100, both flushes=1. Next cycle, if_pc=0x40 -> hit=1, taken=1, pred_pc_o=0x100.
3. Counter training on 0x40, starting from step 2:
   - two not-taken resolves -> pred_taken_o=0 (counter 00);
   - a third not-taken keeps 00;
   - four taken resolves reach 11 and stay at 11.
4. Alias: resolve ex_pc=0x80 (idx 0, tag 2), taken, target=0x200 -> 0x80 hits with pred_pc_o=0x200; 0x40 now misses. A not-taken miss at 0xC0 leaves the table unchanged.
5. Resolve 0x40 taken, target 0x100, id_pc=0x100 -> mispredict_o=0. Non-control EX with id_pc mismatch -> no flush. ex_valid_i=0 -> no flush, no training.
6. Twenty consecutive mispredicts -> mispred_cnt_o=15 (saturated). Drive rst_ni=0 for one cycle while a resolve is present -> next cycle counters=0, 0x40 misses.
